recv_time_module: RTL and testbench

Receive-side counterpart of the time-sync transmitter. It accepts the 64-bit AXI-Stream from the Ethernet MAC RX path, where every beat carries the remote node's local time. It checks each frame's framing and integrity and computes the signed offset between remote time (plus a fixed link delay) and the local time counter. It sits between the MAC RX user interface and the local clock-correction logic.

---
 rtl/recv_time_module.sv | 165 ++++++++++++++++
 tb/tb_recv_time_module.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/recv_time_module.sv
// Receive-side time-sync frame checker: validates framing on the MAC RX stream and
// reports remote + link delay - local. Optional monotonic check: RECV_TIME_MONO_CHK_EN.
module recv_time_module #(
    parameter int unsigned P_FRAME_LEN  = 200,
    parameter logic [63:0] P_LINK_DELAY = 64'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_local_time,
    input  logic        i_stat_rx_status,
    input  logic        i_rx_axis_tvalid,
    input  logic [63:0] i_rx_axis_tdata,
    input  logic        i_rx_axis_tlast,
    input  logic [7:0]  i_rx_axis_tkeep,
    input  logic        i_rx_axis_tuser,
    output logic [63:0] o_offset,
    output logic        o_offset_valid,
    output logic        o_sync_locked,
    output logic [15:0] o_frame_ok_cnt,
    output logic [15:0] o_frame_err_cnt
);

    localparam int unsigned CW = $clog2(P_FRAME_LEN + 1);
    localparam logic [CW-1:0] LEN_C = CW'(P_FRAME_LEN);

    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_BODY, S_DROP} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  r_cnt, cnt_n;
    logic           r_err, err_n;
    logic [63:0]    r_diff, diff_n;
    logic [63:0]    offset_n;
    logic           valid_n, locked_n;
    logic [15:0]    ok_cnt_n, err_cnt_n;
    logic           keep_bad, mono_bad, eof;

`ifdef RECV_TIME_MONO_CHK_EN
    logic [63:0]    r_prev, prev_n;

    assign mono_bad = (i_rx_axis_tdata <= r_prev);
`else
    assign mono_bad = 1'b0;
`endif

    assign keep_bad = (i_rx_axis_tkeep != 8'hff);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= S_IDLE;
            r_cnt           <= '0;
            r_err           <= 1'b0;
            r_diff          <= '0;
            o_offset        <= '0;
            o_offset_valid  <= 1'b0;
            o_sync_locked   <= 1'b0;
            o_frame_ok_cnt  <= '0;
            o_frame_err_cnt <= '0;
`ifdef RECV_TIME_MONO_CHK_EN
            r_prev          <= '0;
`endif
        end else begin
            state           <= state_n;
            r_cnt           <= cnt_n;
            r_err           <= err_n;
            r_diff          <= diff_n;
            o_offset        <= offset_n;
            o_offset_valid  <= valid_n;
            o_sync_locked   <= locked_n;
            o_frame_ok_cnt  <= ok_cnt_n;
            o_frame_err_cnt <= err_cnt_n;
`ifdef RECV_TIME_MONO_CHK_EN
            r_prev          <= prev_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = r_cnt;
        err_n     = r_err;
        diff_n    = r_diff;
        offset_n  = o_offset;
        valid_n   = 1'b0;
        locked_n  = o_sync_locked;
        ok_cnt_n  = o_frame_ok_cnt;
        err_cnt_n = o_frame_err_cnt;
        eof       = 1'b0;
`ifdef RECV_TIME_MONO_CHK_EN
        prev_n    = r_prev;
`endif

        if (!i_stat_rx_status) begin
            // Link drop discards any partial frame silently, even on a tlast beat.
            state_n  = S_IDLE;
            locked_n = 1'b0;
            cnt_n    = '0;
            err_n    = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state_n = S_FIRST;
                end
                S_FIRST: begin
                    if (i_rx_axis_tvalid) begin
                        diff_n = i_rx_axis_tdata + P_LINK_DELAY - i_local_time;
                        cnt_n  = CW'(1);
                        err_n  = keep_bad;
`ifdef RECV_TIME_MONO_CHK_EN
                        prev_n = i_rx_axis_tdata;
`endif
                        if (i_rx_axis_tlast) begin
                            eof = 1'b1;
                        end else if (cnt_n == LEN_C) begin
                            err_n   = 1'b1;
                            state_n = S_DROP;
                        end else begin
                            state_n = S_BODY;
                        end
                    end
                end
                S_BODY: begin
                    if (i_rx_axis_tvalid) begin
                        cnt_n = r_cnt + CW'(1);
                        err_n = r_err | keep_bad | mono_bad;
`ifdef RECV_TIME_MONO_CHK_EN
                        prev_n = i_rx_axis_tdata;
`endif
                        if (i_rx_axis_tlast) begin
                            eof = 1'b1;
                        end else if (cnt_n == LEN_C) begin
                            err_n   = 1'b1;
                            state_n = S_DROP;
                        end
                    end
                end
                S_DROP: begin
                    if (i_rx_axis_tvalid && i_rx_axis_tlast) begin
                        err_cnt_n = o_frame_err_cnt + 16'd1;
                        cnt_n     = '0;
                        err_n     = 1'b0;
                        state_n   = S_FIRST;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase

            if (eof) begin
                state_n = S_FIRST;
                if ((cnt_n == LEN_C) && !i_rx_axis_tuser && !err_n) begin
                    offset_n = diff_n;
                    valid_n  = 1'b1;
                    locked_n = 1'b1;
                    ok_cnt_n = o_frame_ok_cnt + 16'd1;
                end else begin
                    err_cnt_n = o_frame_err_cnt + 16'd1;
                end
                cnt_n = '0;
                err_n = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_recv_time_module.sv
// Directed bench for recv_time_module: framing, offset arithmetic, link drop and the
// optional monotonic check (follows RECV_TIME_MONO_CHK_EN).
module tb_recv_time_module;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] local_time;
    logic        status;
    logic        tvalid;
    logic [63:0] tdata;
    logic        tlast;
    logic [7:0]  tkeep;
    logic        tuser;

    logic [63:0] offset, offset0;
    logic        offset_valid, offset_valid0;
    logic        locked, locked0;
    logic [15:0] ok_cnt, ok_cnt0;
    logic [15:0] err_cnt, err_cnt0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    recv_time_module #(
        .P_FRAME_LEN (200),
        .P_LINK_DELAY(64'd5)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_local_time    (local_time),
        .i_stat_rx_status(status),
        .i_rx_axis_tvalid(tvalid),
        .i_rx_axis_tdata (tdata),
        .i_rx_axis_tlast (tlast),
        .i_rx_axis_tkeep (tkeep),
        .i_rx_axis_tuser (tuser),
        .o_offset        (offset),
        .o_offset_valid  (offset_valid),
        .o_sync_locked   (locked),
        .o_frame_ok_cnt  (ok_cnt),
        .o_frame_err_cnt (err_cnt)
    );

    // Zero-delay instance sees the same stream; used for the raw-offset cases.
    recv_time_module #(
        .P_FRAME_LEN (200),
        .P_LINK_DELAY(64'd0)
    ) dut0 (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_local_time    (local_time),
        .i_stat_rx_status(status),
        .i_rx_axis_tvalid(tvalid),
        .i_rx_axis_tdata (tdata),
        .i_rx_axis_tlast (tlast),
        .i_rx_axis_tkeep (tkeep),
        .i_rx_axis_tuser (tuser),
        .o_offset        (offset0),
        .o_offset_valid  (offset_valid0),
        .o_sync_locked   (locked0),
        .o_frame_ok_cnt  (ok_cnt0),
        .o_frame_err_cnt (err_cnt0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beat k (1-based) carries base+k-1; local time advances by one per beat from lt0.
    task automatic send(input logic [63:0] base, input logic [63:0] lt0, input int nbeats,
                        input int gap_beat, input logic [15:0] gap_err, input int keep_beat,
                        input bit tuser_last, input int rep_beat, input int drop_beat,
                        input bit hold);
        for (int k = 1; k <= nbeats; k++) begin
            if (k == gap_beat) begin
                @(negedge clk);
                tvalid = 1'b0;
                tlast  = 1'b0;
                chk("gap_err_cnt", 64'(err_cnt), 64'(gap_err));
            end
            @(negedge clk);
            tvalid     = 1'b1;
            tdata      = (k == rep_beat) ? base + 64'(k) - 64'd2 : base + 64'(k) - 64'd1;
            tkeep      = (k == keep_beat) ? 8'h0f : 8'hff;
            tlast      = (k == nbeats);
            tuser      = (k == nbeats) && tuser_last;
            local_time = lt0 + 64'(k) - 64'd1;
            if (k == drop_beat) begin
                status = 1'b0;
                @(negedge clk);
                tvalid = 1'b0;
                tlast  = 1'b0;
                tuser  = 1'b0;
                return;
            end
        end
        if (!hold) begin
            @(negedge clk);
            tvalid = 1'b0;
            tlast  = 1'b0;
            tuser  = 1'b0;
        end
    endtask

    initial begin
        rst        = 1'b1;
        status     = 1'b0;
        tvalid     = 1'b0;
        tdata      = '0;
        tlast      = 1'b0;
        tkeep      = 8'hff;
        tuser      = 1'b0;
        local_time = '0;

        @(negedge clk);
        chk("rst_offset", offset, 64'd0);
        chk("rst_valid", 64'(offset_valid), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_ok_cnt", 64'(ok_cnt), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;

        // Beats while the link is down must be ignored.
        @(negedge clk);
        tvalid = 1'b1;
        tlast  = 1'b1;
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
        chk("idle_err_cnt", 64'(err_cnt), 64'd0);
        status = 1'b1;
        repeat (2) @(negedge clk);

        // 1000+5-900 = 105 ; zero-delay instance 100. Gap inside the frame.
        send(64'd1000, 64'd900, 200, 7, 16'd0, 0, 1'b0, 0, 0, 1'b0);
        chk("f1_offset", offset, 64'd105);
        chk("f1_offset0", offset0, 64'd100);
        chk("f1_valid", 64'(offset_valid), 64'd1);
        chk("f1_ok_cnt", 64'(ok_cnt), 64'd1);
        chk("f1_locked", 64'(locked), 64'd1);
        @(negedge clk);
        chk("f1_valid_1cyc", 64'(offset_valid), 64'd0);

        // Remote 100, local 200: -100 with no delay, -95 with delay 5.
        send(64'd100, 64'd200, 200, 0, 16'd0, 0, 1'b0, 0, 0, 1'b0);
        chk("f2_offset0", offset0, 64'hffff_ffff_ffff_ff9c);
        chk("f2_offset", offset, 64'hffff_ffff_ffff_ffa1);
        chk("f2_ok_cnt", 64'(ok_cnt), 64'd2);

        // Early tlast.
        send(64'd3000, 64'd10, 150, 0, 16'd0, 0, 1'b0, 0, 0, 1'b0);
        chk("early_err_cnt", 64'(err_cnt), 64'd1);
        chk("early_valid", 64'(offset_valid), 64'd0);
        chk("early_offset", offset, 64'hffff_ffff_ffff_ffa1);

        // Overlength: error counted only at the eventual tlast.
        send(64'd4000, 64'd10, 250, 250, 16'd1, 0, 1'b0, 0, 0, 1'b0);
        chk("long_err_cnt", 64'(err_cnt), 64'd2);
        chk("long_ok_cnt", 64'(ok_cnt), 64'd2);

        // Good frame, then a back-to-back good frame.
        send(64'd5000, 64'd4000, 200, 0, 16'd0, 0, 1'b0, 0, 0, 1'b0);
        chk("f6_ok_cnt", 64'(ok_cnt), 64'd3);
        chk("f6_offset", offset, 64'd1005);
        send(64'd6000, 64'd5000, 200, 0, 16'd0, 0, 1'b0, 0, 0, 1'b1);
        send(64'd7000, 64'd6500, 200, 0, 16'd0, 0, 1'b0, 0, 0, 1'b0);
        chk("b2b_ok_cnt", 64'(ok_cnt), 64'd5);
        chk("b2b_offset", offset, 64'd505);
        chk("b2b_valid", 64'(offset_valid), 64'd1);

        // tuser on tlast, then bad tkeep on beat 10.
        send(64'd8000, 64'd10, 200, 0, 16'd0, 0, 1'b1, 0, 0, 1'b0);
        chk("tuser_err_cnt", 64'(err_cnt), 64'd3);
        send(64'd8000, 64'd10, 200, 0, 16'd0, 10, 1'b0, 0, 0, 1'b0);
        chk("tkeep_err_cnt", 64'(err_cnt), 64'd4);
        chk("tkeep_ok_cnt", 64'(ok_cnt), 64'd5);
        chk("tkeep_offset", offset, 64'd505);

        // Link drop at beat 100.
        send(64'd8000, 64'd10, 200, 0, 16'd0, 0, 1'b0, 0, 100, 1'b0);
        repeat (2) @(negedge clk);
        chk("drop_locked", 64'(locked), 64'd0);
        chk("drop_ok_cnt", 64'(ok_cnt), 64'd5);
        chk("drop_err_cnt", 64'(err_cnt), 64'd4);
        chk("drop_offset", offset, 64'd505);
        status = 1'b1;
        repeat (2) @(negedge clk);
        chk("restore_locked", 64'(locked), 64'd0);
        send(64'd9000, 64'd8000, 200, 0, 16'd0, 0, 1'b0, 0, 0, 1'b0);
        chk("relock_ok_cnt", 64'(ok_cnt), 64'd6);
        chk("relock_locked", 64'(locked), 64'd1);

        // Link drop on the tlast beat wins.
        send(64'd9000, 64'd100, 200, 0, 16'd0, 0, 1'b0, 0, 200, 1'b0);
        chk("droplast_valid", 64'(offset_valid), 64'd0);
        @(negedge clk);
        chk("droplast_ok_cnt", 64'(ok_cnt), 64'd6);
        chk("droplast_err_cnt", 64'(err_cnt), 64'd4);
        chk("droplast_offset", offset, 64'd1005);
        status = 1'b1;
        repeat (2) @(negedge clk);

        // Beat 50 repeats beat 49.
        send(64'd9000, 64'd8000, 200, 0, 16'd0, 0, 1'b0, 50, 0, 1'b0);
`ifdef RECV_TIME_MONO_CHK_EN
        chk("mono_err_cnt", 64'(err_cnt), 64'd5);
        chk("mono_ok_cnt", 64'(ok_cnt), 64'd6);
`else
        chk("mono_err_cnt", 64'(err_cnt), 64'd4);
        chk("mono_ok_cnt", 64'(ok_cnt), 64'd7);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
